// File: rtl/handshake_pkg.sv
// -----------------------------------------------------------------------------
// handshake_pkg
// Shared definitions for the round-robin merge buffer.
//   - idx_w()  : bits needed to index n items (at least 1).
//   - cnt_w()  : bits needed to hold a count 0..n.
//   - DEF_*    : default configuration of handshake_rr_buffer.
//   - SRC_W / CNT_W / fifo_entry_t : widths and entry layout for that
//     default configuration (used by code that talks to the default build).
// -----------------------------------------------------------------------------
package handshake_pkg;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_NUM_IN  = 3;
    localparam int DEF_DEPTH   = 2;
    localparam int DEF_STALL_W = 8;

    localparam int SRC_W = idx_w(DEF_NUM_IN);
    localparam int CNT_W = cnt_w(DEF_DEPTH);

    typedef struct packed {
        logic [SRC_W-1:0]     src;
        logic [DEF_WIDTH-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first asserted request found
// when scanning cyclically upward from rr_ptr.
//   req       in  NUM_IN  request vector
//   rr_ptr    in  SRC     highest-priority channel this cycle (< NUM_IN)
//   grant_oh  out NUM_IN  one-hot grant (all zero when none)
//   grant_idx out SRC     index of granted channel (0 when none)
//   none      out 1       no request asserted
// -----------------------------------------------------------------------------
module rr_arbiter
    import handshake_pkg::*;
#(
    parameter int NUM_IN = DEF_NUM_IN
) (
    input  logic [NUM_IN-1:0]        req,
    input  logic [idx_w(NUM_IN)-1:0] rr_ptr,
    output logic [NUM_IN-1:0]        grant_oh,
    output logic [idx_w(NUM_IN)-1:0] grant_idx,
    output logic                     none
);

    localparam int SRC_BITS = idx_w(NUM_IN);

    logic [SRC_BITS:0]   cand;
    logic [SRC_BITS-1:0] idx;

    // NOTE: every output and temporary gets a default before the loop so no
    // path through the block leaves a value unassigned (which would infer a latch).
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        none      = 1'b1;
        cand      = '0;
        idx       = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            // Wrap by compare-and-subtract so non-power-of-two NUM_IN never
            // produces an index past the last channel.
            cand = {1'b0, rr_ptr} + (SRC_BITS+1)'(k);
            if (cand >= (SRC_BITS+1)'(NUM_IN)) begin
                cand = cand - (SRC_BITS+1)'(NUM_IN);
            end
            idx = cand[SRC_BITS-1:0];
            if (none && req[idx]) begin
                grant_oh[idx] = 1'b1;
                grant_idx     = idx;
                none          = 1'b0;
            end
        end
    end

endmodule

// File: rtl/handshake_rr_buffer.sv
// -----------------------------------------------------------------------------
// handshake_rr_buffer
// Merges NUM_IN valid/ready channels into one through a round-robin arbiter
// and a DEPTH-entry registered FIFO. Outputs come only from flops/storage.
//   CLK, ASYNCRESET          clock (rising) and async active-high reset
//   handshake_arr_valid/ready per-channel upstream handshake
//   arr_data                 channel i at [i*WIDTH +: WIDTH]
//   handshake_valid/ready    merged downstream handshake
//   out_data, out_src        head entry data and originating channel
//   out                      |out_data
//   stall_cnt                saturating count of valid && !ready cycles
// -----------------------------------------------------------------------------
module handshake_rr_buffer
    import handshake_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NUM_IN  = DEF_NUM_IN,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int STALL_W = DEF_STALL_W
) (
    input  logic                     CLK,
    input  logic                     ASYNCRESET,
    input  logic [NUM_IN-1:0]        handshake_arr_valid,
    output logic [NUM_IN-1:0]        handshake_arr_ready,
    input  logic [NUM_IN*WIDTH-1:0]  arr_data,
    output logic                     handshake_valid,
    input  logic                     handshake_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [idx_w(NUM_IN)-1:0] out_src,
    output logic                     out,
    output logic [STALL_W-1:0]       stall_cnt
);

    localparam int SRC_BITS  = idx_w(NUM_IN);
    localparam int ADDR_BITS = idx_w(DEPTH);
    localparam int CNT_BITS  = cnt_w(DEPTH);

    typedef struct packed {
        logic [SRC_BITS-1:0] src;
        logic [WIDTH-1:0]    data;
    } entry_t;

    entry_t               mem_q [DEPTH];
    entry_t               mem_d [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]  count_q, count_d;
    logic [SRC_BITS-1:0]  rr_ptr_q, rr_ptr_d;
    logic [STALL_W-1:0]   stall_q, stall_d;

    logic [NUM_IN-1:0]    grant_oh;
    logic [SRC_BITS-1:0]  grant_idx;
    logic                 none;
    logic                 space, push, pop;
    logic [WIDTH-1:0]     sel_data;

    rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
        .req       (handshake_arr_valid),
        .rr_ptr    (rr_ptr_q),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .none      (none)
    );

    // Space is judged on the registered count only, so a same-cycle pop never
    // opens a slot. Ready is also held low while reset is asserted.
    always_comb begin
        space               = (count_q < CNT_BITS'(DEPTH)) && !ASYNCRESET;
        handshake_arr_ready = (space && !none) ? grant_oh : '0;
        push                = space && !none;
        handshake_valid     = (count_q != '0);
        pop                 = handshake_valid && handshake_ready;

        sel_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_oh[i]) sel_data = sel_data | arr_data[i*WIDTH +: WIDTH];
        end
    end

    // NOTE: next-state logic uses blocking '=' (combinational); the state
    // register below uses non-blocking '<=' so all flops update together.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rr_ptr_d = rr_ptr_q;
        stall_d  = stall_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{src: grant_idx, data: sel_data};
            wr_ptr_d        = wr_ptr_q + ADDR_BITS'(1);
            rr_ptr_d        = (grant_idx == SRC_BITS'(NUM_IN - 1)) ? '0
                                                                   : grant_idx + SRC_BITS'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase

        if (handshake_valid && !handshake_ready && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    // NOTE: the storage array is reset too, so the head (and therefore
    // out_data/out) is guaranteed zero the moment reset asserts.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
            stall_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
            stall_q  <= stall_d;
        end
    end

    assign out_data  = mem_q[rd_ptr_q].data;
    assign out_src   = mem_q[rd_ptr_q].src;
    assign out       = |out_data;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_handshake_rr_buffer.sv
// -----------------------------------------------------------------------------
// tb_handshake_rr_buffer
// Self-checking bench: a negedge monitor keeps a scoreboard of accepted
// entries and compares each popped head; directed sequences cover reset,
// arbitration order, full/backpressure and stall saturation.
// -----------------------------------------------------------------------------
module tb_handshake_rr_buffer;
    import handshake_pkg::*;

    localparam int NI  = DEF_NUM_IN;
    localparam int W   = DEF_WIDTH;
    localparam int SW  = DEF_STALL_W;
    localparam int SAT = (1 << SW) - 1;

    logic             CLK = 1'b0;
    logic             ASYNCRESET = 1'b1;
    logic [NI-1:0]    arr_valid;
    logic [NI-1:0]    arr_ready;
    logic [NI*W-1:0]  arr_data;
    logic             hs_valid;
    logic             hs_ready;
    logic [W-1:0]     out_data;
    logic [SRC_W-1:0] out_src;
    logic             out;
    logic [SW-1:0]    stall_cnt;

    int total = 0;
    int bad   = 0;

    fifo_entry_t      sb_q[$];
    logic [SRC_W-1:0] src_log[$];
    fifo_entry_t      ent, exp_e, last_head;
    int               model_stall = 0;
    logic             hold = 1'b0;

    handshake_rr_buffer #(
        .WIDTH(W), .NUM_IN(NI), .DEPTH(DEF_DEPTH), .STALL_W(SW)
    ) dut (
        .CLK                 (CLK),
        .ASYNCRESET          (ASYNCRESET),
        .handshake_arr_valid (arr_valid),
        .handshake_arr_ready (arr_ready),
        .arr_data            (arr_data),
        .handshake_valid     (hs_valid),
        .handshake_ready     (hs_ready),
        .out_data            (out_data),
        .out_src             (out_src),
        .out                 (out),
        .stall_cnt           (stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: sampled mid-cycle, while inputs and outputs are stable.
    always @(negedge CLK) begin
        if (ASYNCRESET) begin
            sb_q.delete();
            model_stall = 0;
            hold        = 1'b0;
        end else begin
            check("one_ready", 32'($countones(arr_ready) <= 1), 1);
            check("valid_vs_model", hs_valid, sb_q.size() != 0);
            check("out_or", out, |out_data);
            check("stall_cnt", stall_cnt, model_stall);
            if (hold) begin
                check("hold_data", out_data, last_head.data);
                check("hold_src", out_src, last_head.src);
            end
            if (hs_valid && hs_ready) begin
                if (sb_q.size() == 0) begin
                    check("pop_nonempty", 0, 1);
                end else begin
                    exp_e = sb_q.pop_front();
                    check("head_data", out_data, exp_e.data);
                    check("head_src", out_src, exp_e.src);
                    src_log.push_back(out_src);
                end
            end
            for (int i = 0; i < NI; i++) begin
                if (arr_valid[i] && arr_ready[i]) begin
                    ent.src  = SRC_W'(i);
                    ent.data = arr_data[i*W +: W];
                    sb_q.push_back(ent);
                end
            end
            hold           = hs_valid && !hs_ready;
            last_head.src  = out_src;
            last_head.data = out_data;
            if (hold && model_stall < SAT) model_stall++;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Asserted between edges with valids high: outputs must clear at once.
    task automatic do_reset();
        arr_valid  = '1;
        ASYNCRESET = 1'b1;
        #1;
        check("rst_valid", hs_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_src", out_src, 0);
        check("rst_out", out, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_ready", arr_ready, 0);
        repeat (2) tick();
        ASYNCRESET = 1'b0;
        arr_valid  = '0;
        hs_ready   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arr_valid = '0;
        arr_data  = '0;
        hs_ready  = 1'b0;
        #2;

        // Reset then idle.
        do_reset();
        repeat (3) tick();
        check("idle_valid", hs_valid, 0);
        check("idle_ready", arr_ready, 0);

        // All channels valid, sink always ready: strict rotation 0,1,2,...
        do_reset();
        src_log.delete();
        arr_data  = {4'h3, 4'h2, 4'h1};
        arr_valid = '1;
        hs_ready  = 1'b1;
        repeat (12) tick();
        arr_valid = '0;
        repeat (3) tick();
        check("rr_pops", src_log.size(), 12);
        for (int i = 0; i < 12 && i < src_log.size(); i++) check("rr_order", src_log[i], i % 3);

        // Lone channel 2 with zero data: visible one cycle after accept.
        do_reset();
        arr_data  = {4'h0, 4'hA, 4'h5};
        arr_valid = 3'b100;
        hs_ready  = 1'b1;
        @(negedge CLK);
        check("ch2_ready", arr_ready, 3'b100);
        check("ch2_pre_valid", hs_valid, 0);
        tick();
        arr_valid = '0;
        @(negedge CLK);
        check("ch2_valid", hs_valid, 1);
        check("ch2_data", out_data, 0);
        check("ch2_out", out, 0);
        check("ch2_src", out_src, 2);
        repeat (2) tick();

        // Backpressure: two accepts fill the FIFO, stall counter saturates.
        do_reset();
        arr_data  = {4'h9, 4'h6, 4'hC};
        arr_valid = '1;
        hs_ready  = 1'b0;
        repeat (2) tick();
        @(negedge CLK);
        check("full_ready", arr_ready, 0);
        check("full_head_data", out_data, 4'hC);
        check("full_head_src", out_src, 0);
        repeat (300) tick();
        check("stall_sat", stall_cnt, SAT);
        repeat (5) tick();
        check("stall_hold", stall_cnt, SAT);

        // Full FIFO: pop cycle keeps ready low, refill follows (2->1->2).
        hs_ready = 1'b1;
        @(negedge CLK);
        check("pop_cycle_ready", arr_ready, 0);
        tick();
        hs_ready = 1'b0;
        @(negedge CLK);
        check("after_pop_ready", arr_ready, 3'b100);
        check("after_pop_head", out_data, 4'h6);
        tick();
        @(negedge CLK);
        check("refull_ready", arr_ready, 0);
        check("refull_valid", hs_valid, 1);

        // Random traffic, scoreboard checks ordering.
        do_reset();
        for (int c = 0; c < 200; c++) begin
            arr_valid = NI'($urandom);
            arr_data  = (NI*W)'($urandom);
            hs_ready  = 1'($urandom_range(0, 1));
            tick();
        end

        // Drain with a bounded wait.
        arr_valid = '0;
        hs_ready  = 1'b1;
        for (int c = 0; c < 20 && sb_q.size() != 0; c++) tick();
        check("drain", sb_q.size(), 0);

        // Reset mid-transfer with a full FIFO of non-zero data.
        arr_data  = '1;
        arr_valid = '1;
        hs_ready  = 1'b0;
        repeat (3) tick();
        check("pre_rst_out", out, 1);
        do_reset();
        repeat (2) tick();
        check("post_rst_valid", hs_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/handshake_rr_buffer.md
Name: handshake_rr_buffer

Overview:
Round-robin arbiter plus small FIFO that merges NUM_IN upstream valid/ready channels into one downstream valid/ready channel.
- Sits directly upstream of the RTL monitor stage.
- Drives the per-channel handshake_arr_* pairs, the merged handshake_valid/handshake_ready pair and the data the monitor checks.
- Registered FIFO, no combinational data bypass, so arbitration and storage timing are deterministic for formal properties.

Parameters:
- WIDTH, 4: data width per channel.
- NUM_IN, 3: number of upstream channels (2..8).
- DEPTH, 2: FIFO entries (power of two, >=2).
- STALL_W, 8: width of the saturating stall counter.

Ports:
- CLK  input  1  clock, rising edge.
- ASYNCRESET  input  1  asynchronous, active-high reset.
- handshake_arr_valid  input  NUM_IN  per-channel upstream valid.
- handshake_arr_ready  output  NUM_IN  per-channel upstream ready.
- arr_data  input  NUM_IN*WIDTH  per-channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- handshake_valid  output  1  FIFO head valid.
- handshake_ready  input  1  downstream ready.
- out_data  output  WIDTH  FIFO head data.
- out_src  output  clog2(NUM_IN)  channel index of head entry.
- out  output  1  reduction-OR of out_data.
- stall_cnt  output  STALL_W  saturating count of cycles with handshake_valid && !handshake_ready.

Behaviour:
- Reset (ASYNCRESET=1, takes effect immediately, independent of CLK):
  - count=0, rd/wr pointers=0, rr_ptr=0, stall_cnt=0.
  - All storage entries cleared to 0.
  - handshake_valid=0, out_data=0, out_src=0, out=0, handshake_arr_ready=0.
- Accept condition: space = (count < DEPTH).
  - A pop in the same cycle does NOT create space (no pass-through when full).
- Arbitration (combinational):
  - grant = first i with handshake_arr_valid[i]=1, searching cyclically from rr_ptr.
  - none = no valid asserted.
- handshake_arr_ready[i] = space && !none && grant==i.
  - At most one ready high per cycle.
  - Ready may depend on valid; upstream must not depend on ready to raise valid.
- Push: any handshake_arr_valid[i] && handshake_arr_ready[i].
  - Writes {i, data_i} at wr_ptr.
  - wr_ptr++ (wraps mod DEPTH).
  - rr_ptr <= (grant+1) mod NUM_IN.
  - rr_ptr is unchanged when there is no push.
- Pop: handshake_valid && handshake_ready.
  - rd_ptr++ (wraps mod DEPTH).
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Output side:
  - handshake_valid = (count != 0).
  - out_data and out_src = head entry.
  - out = |out_data.
  - All outputs are driven from registers or storage, never from the arr_* inputs.
- Latency: push at edge N makes the data visible on out_data after edge N, i.e. 1 cycle minimum.
- Ordering: strict FIFO; data and src never reorder.
- Stability: while handshake_valid && !handshake_ready, out_data, out_src and out hold constant.
- stall_cnt: increments each cycle with handshake_valid && !handshake_ready; saturates at all-ones; never clears except on reset.
- Reset asserted mid-transfer: in-flight entries are discarded; no output glitch to a non-reset value after the reset edge.
- Invalid rr_ptr value (NUM_IN not a power of two): unreachable by construction; the wrap logic must use compare-and-reset, not modulo by truncation.

Decomposition:
- Shared package handshake_pkg:
  - constants SRC_W = clog2(NUM_IN) and CNT_W = clog2(DEPTH+1).
  - typedef fifo_entry_t = struct {src, data}.
- One natural sub-module: rr_arbiter (request vector + rr_ptr -> one-hot grant, grant index, none).
- FIFO storage, pointers and counters live in the top.

Test Plan:
- Reset then idle: all outputs 0; assert ASYNCRESET between edges -> outputs return to 0 before the next CLK edge.
- All three valid every cycle, ready=1, data ch0=0x1, ch1=0x2, ch2=0x3 -> out_data sequence 0x1,0x2,0x3,0x1,...; out_src 0,1,2,0; out=1 throughout.
- Only ch2 valid with data 0x0, ready=1 -> out_data=0x0, out=0, out_src=2, one cycle after accept.
- handshake_ready=0 with continuous pushes -> after 2 accepts all handshake_arr_ready=0; head held stable; stall_cnt increments to 255 and stays.
- Full FIFO with ready=1 and valid pending -> pop cycle shows ready=0; push occurs the following cycle; count goes 2->1->2.
- Simultaneous push and pop at count=1 over 10 cycles -> count stays 1; order preserved; rr_ptr advances each push.
